// File: rtl/counter_mode_arbiter_pkg.sv
// counter_mode_arbiter_pkg: shared view/state encoding, button indices and display constants
package counter_mode_arbiter_pkg;
  typedef enum logic [1:0] {CD_VIEW = 2'd0, SW_VIEW = 2'd1, ALARM = 2'd2} state_t;
  localparam int BTN_L = 4;
  localparam int BTN_R = 3;
  localparam int BTN_U = 2;
  localparam int BTN_D = 1;
  localparam int BTN_C = 0;
  localparam logic [1:0] TARGET_RUN = 2'b11;
endpackage

// File: rtl/counter_mode_arbiter_if.sv
// counter_mode_arbiter_if: button, channel and display signals around the view arbiter
interface counter_mode_arbiter_if;
  logic       tick_10ms;
  logic       mode_button;
  logic [4:0] btn_i;
  logic       time_out_i;
  logic [7:0] cd_min_i, cd_sec_i, cd_ms_10_i;
  logic [1:0] cd_target_i;
  logic [7:0] sw_min_i, sw_sec_i, sw_ms_10_i;
  logic [1:0] sw_target_i;
  logic [4:0] cd_btn_o, sw_btn_o;
  logic [7:0] min_o, sec_o, ms_10_o;
  logic [1:0] target_o;
  logic       mode_o, alarm_o, blank_o;
  modport master (
    output tick_10ms, mode_button, btn_i, time_out_i,
           cd_min_i, cd_sec_i, cd_ms_10_i, cd_target_i,
           sw_min_i, sw_sec_i, sw_ms_10_i, sw_target_i,
    input  cd_btn_o, sw_btn_o, min_o, sec_o, ms_10_o, target_o, mode_o, alarm_o, blank_o
  );
  modport slave (
    input  tick_10ms, mode_button, btn_i, time_out_i,
           cd_min_i, cd_sec_i, cd_ms_10_i, cd_target_i,
           sw_min_i, sw_sec_i, sw_ms_10_i, sw_target_i,
    output cd_btn_o, sw_btn_o, min_o, sec_o, ms_10_o, target_o, mode_o, alarm_o, blank_o
  );
endinterface

// File: rtl/counter_mode_arbiter_timer.sv
// alarm_blink_timer: alarm duration and blink counters, blank toggle and done strobe
module alarm_blink_timer #(
  parameter int BLINK_TICKS = 50,
  parameter int ALARM_TICKS = 3000,
  parameter int CNT_W = 12
) (
  input  logic clk_core,
  input  logic rst,
  input  logic start,
  input  logic clear,
  input  logic run,
  input  logic tick,
  output logic blank,
  output logic done
);
  logic [CNT_W-1:0] blink_cnt, alarm_cnt;
  logic wrap;
  assign wrap = blink_cnt == CNT_W'(BLINK_TICKS - 1);
  assign done = run & tick & (alarm_cnt == CNT_W'(ALARM_TICKS - 1));
  always_ff @(posedge clk_core) begin
    if (rst || start || clear) begin
      blink_cnt <= '0;
      alarm_cnt <= '0;
      blank     <= 1'b0;
    end else if (run && tick) begin
      alarm_cnt <= alarm_cnt + 1'b1;
      blink_cnt <= wrap ? '0 : blink_cnt + 1'b1;
      blank     <= blank ^ wrap;
    end
  end
endmodule

// File: rtl/counter_mode_arbiter.sv
// counter_mode_arbiter: routes buttons and display between countdown/stopwatch and runs the timeout alarm
module counter_mode_arbiter
  import counter_mode_arbiter_pkg::*;
#(
  parameter int BLINK_TICKS = 50,
  parameter int ALARM_TICKS = 3000,
  parameter int CNT_W = 12
) (
  input logic clk_core,
  input logic rst,
  counter_mode_arbiter_if.slave bus
);
  state_t state, nstate, ret_view;
  logic timeout_q, to_rise, ack, done, fwd;
  assign to_rise = bus.time_out_i & ~timeout_q;
  assign ack = (|bus.btn_i) | bus.mode_button;
  assign fwd = state != ALARM && !to_rise && !bus.mode_button;
  always_comb begin
    nstate = state;
    if (to_rise) nstate = ALARM;
    else if (state == ALARM) nstate = ack ? CD_VIEW : done ? ret_view : ALARM;
    else if (bus.mode_button) nstate = state == CD_VIEW ? SW_VIEW : CD_VIEW;
  end
  alarm_blink_timer #(.BLINK_TICKS(BLINK_TICKS), .ALARM_TICKS(ALARM_TICKS), .CNT_W(CNT_W)) u_timer (
    .clk_core (clk_core),
    .rst      (rst),
    .start    (to_rise),
    .clear    (state == ALARM && nstate != ALARM),
    .run      (state == ALARM),
    .tick     (bus.tick_10ms),
    .blank    (bus.blank_o),
    .done     (done)
  );
  always_ff @(posedge clk_core) begin
    if (rst) begin
      state        <= CD_VIEW;
      ret_view     <= CD_VIEW;
      timeout_q    <= 1'b1;
      bus.cd_btn_o <= '0;
      bus.sw_btn_o <= '0;
      bus.min_o    <= '0;
      bus.sec_o    <= '0;
      bus.ms_10_o  <= '0;
      bus.target_o <= '0;
      bus.mode_o   <= 1'b0;
      bus.alarm_o  <= 1'b0;
    end else begin
      state        <= nstate;
      timeout_q    <= bus.time_out_i;
      if (to_rise && state != ALARM) ret_view <= state;
      bus.cd_btn_o <= (fwd && state == CD_VIEW) ? bus.btn_i : '0;
      bus.sw_btn_o <= (fwd && state == SW_VIEW) ? bus.btn_i : '0;
      bus.min_o    <= nstate == SW_VIEW ? bus.sw_min_i : bus.cd_min_i;
      bus.sec_o    <= nstate == SW_VIEW ? bus.sw_sec_i : bus.cd_sec_i;
      bus.ms_10_o  <= nstate == SW_VIEW ? bus.sw_ms_10_i : bus.cd_ms_10_i;
      bus.target_o <= nstate == ALARM ? TARGET_RUN : nstate == SW_VIEW ? bus.sw_target_i : bus.cd_target_i;
      bus.mode_o   <= nstate == SW_VIEW;
      bus.alarm_o  <= nstate == ALARM;
    end
  end
endmodule

// File: tb/tb_counter_mode_arbiter.sv
// tb_counter_mode_arbiter: random and directed stimulus checked every cycle against a behavioural model
module tb_counter_mode_arbiter;
  logic clk_core = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int passed = 0;
  always #5 clk_core = ~clk_core;
  counter_mode_arbiter_if bus();
  counter_mode_arbiter dut (.clk_core(clk_core), .rst(rst), .bus(bus));

  int  m_view, m_ret, m_ticks;
  bit  m_alarm, m_tq;
  logic [4:0] e_cd_btn, e_sw_btn;
  logic [7:0] e_min, e_sec, e_ms;
  logic [1:0] e_tgt;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_step();
    bit rise;
    e_cd_btn = '0;
    e_sw_btn = '0;
    if (rst) begin
      m_view = 0; m_ret = 0; m_ticks = 0; m_alarm = 0; m_tq = 1;
      e_min = '0; e_sec = '0; e_ms = '0; e_tgt = '0;
      return;
    end
    rise = bus.time_out_i && !m_tq;
    m_tq = bus.time_out_i;
    if (rise) begin
      if (!m_alarm) m_ret = m_view;
      m_alarm = 1; m_ticks = 0;
    end else if (m_alarm) begin
      if (bus.btn_i != 0 || bus.mode_button) begin
        m_alarm = 0; m_view = 0;
      end else if (bus.tick_10ms) begin
        if (m_ticks == 2999) begin
          m_alarm = 0; m_view = m_ret;
        end else m_ticks++;
      end
    end else if (bus.mode_button) m_view ^= 1;
    else if (m_view == 0) e_cd_btn = bus.btn_i;
    else e_sw_btn = bus.btn_i;
    if (!m_alarm && m_view == 1) begin
      e_min = bus.sw_min_i; e_sec = bus.sw_sec_i; e_ms = bus.sw_ms_10_i; e_tgt = bus.sw_target_i;
    end else begin
      e_min = bus.cd_min_i; e_sec = bus.cd_sec_i; e_ms = bus.cd_ms_10_i;
      e_tgt = m_alarm ? 2'b11 : bus.cd_target_i;
    end
  endtask

  task automatic cyc();
    @(posedge clk_core);
    model_step();
    @(negedge clk_core);
    check("outputs",
      {bus.cd_btn_o, bus.sw_btn_o, bus.min_o, bus.sec_o, bus.ms_10_o, bus.target_o, bus.mode_o, bus.alarm_o, bus.blank_o},
      {e_cd_btn, e_sw_btn, e_min, e_sec, e_ms, e_tgt, 1'(!m_alarm && m_view == 1), m_alarm,
       1'(m_alarm && ((m_ticks / 50) % 2 == 1))});
  endtask

  task automatic cycs(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic rise_timeout();
    bus.time_out_i = 1'b0; cyc();
    bus.time_out_i = 1'b1; cyc();
  endtask

  initial begin
    bus.tick_10ms = 0; bus.mode_button = 0; bus.btn_i = '0; bus.time_out_i = 1'b1;
    bus.cd_min_i = 8'h10; bus.cd_sec_i = 8'h20; bus.cd_ms_10_i = 8'h30; bus.cd_target_i = 2'd1;
    bus.sw_min_i = 8'h01; bus.sw_sec_i = 8'h42; bus.sw_ms_10_i = 8'h03; bus.sw_target_i = 2'd2;
    cycs(2);
    check("rst_min", bus.min_o, 8'h00);
    check("rst_target", bus.target_o, 2'd0);
    check("rst_alarm", bus.alarm_o, 1'b0);
    rst = 1'b0;
    cycs(100);
    check("held_timeout_no_alarm", bus.alarm_o, 1'b0);
    bus.btn_i = 5'b00010; cyc(); bus.btn_i = '0;
    check("up_cd_btn", bus.cd_btn_o, 5'b00010);
    check("up_sw_btn", bus.sw_btn_o, 5'b00000);
    check("cd_min", bus.min_o, 8'h10);
    bus.mode_button = 1; bus.btn_i = 5'b10000; cyc(); bus.mode_button = 0; bus.btn_i = '0;
    check("mode_sw", bus.mode_o, 1'b1);
    check("mode_drop_btn", {bus.cd_btn_o, bus.sw_btn_o}, 10'd0);
    check("sw_sec", bus.sec_o, 8'h42);
    rise_timeout();
    check("alarm_on", bus.alarm_o, 1'b1);
    check("alarm_target", bus.target_o, 2'b11);
    check("alarm_cd_min", bus.min_o, 8'h10);
    bus.tick_10ms = 1;
    cycs(49);
    check("blank_49", bus.blank_o, 1'b0);
    cyc();
    check("blank_50", bus.blank_o, 1'b1);
    cycs(50);
    check("blank_100", bus.blank_o, 1'b0);
    cycs(2899);
    check("alarm_2999", bus.alarm_o, 1'b1);
    cyc();
    check("alarm_3000_off", bus.alarm_o, 1'b0);
    check("return_sw", bus.mode_o, 1'b1);
    bus.tick_10ms = 0;
    rise_timeout();
    bus.tick_10ms = 1; cycs(10); bus.tick_10ms = 0;
    bus.btn_i = 5'b00001; cyc(); bus.btn_i = '0;
    check("ack_alarm_off", bus.alarm_o, 1'b0);
    check("ack_cd_view", bus.mode_o, 1'b0);
    check("ack_consumed", bus.cd_btn_o, 5'b00000);
    rise_timeout();
    bus.tick_10ms = 1; cycs(50); bus.tick_10ms = 0;
    check("pre_rst_blank", bus.blank_o, 1'b1);
    rst = 1; cyc(); rst = 0;
    check("mid_rst_outputs", {bus.alarm_o, bus.blank_o, bus.mode_o, bus.min_o, bus.target_o}, 13'd0);
    cycs(20);
    check("rst_no_realarm", bus.alarm_o, 1'b0);
    for (int i = 0; i < 30000; i++) begin
      bus.tick_10ms   = i < 20000 ? ($urandom_range(3) == 0) : 1'b1;
      bus.mode_button = i < 20000 ? ($urandom_range(299) == 0) : ($urandom_range(3999) == 0);
      bus.btn_i       = (i < 20000 ? ($urandom_range(299) == 0) : ($urandom_range(3999) == 0)) ? 5'($urandom_range(1, 31)) : 5'd0;
      if ($urandom_range(199) == 0) bus.time_out_i = ~bus.time_out_i;
      rst = $urandom_range(4999) == 0;
      bus.cd_min_i = 8'($urandom); bus.cd_sec_i = 8'($urandom); bus.cd_ms_10_i = 8'($urandom);
      bus.sw_min_i = 8'($urandom); bus.sw_sec_i = 8'($urandom); bus.sw_ms_10_i = 8'($urandom);
      bus.cd_target_i = 2'($urandom); bus.sw_target_i = 2'($urandom);
      cyc();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
